// File: rtl/clock_disp_pkg.sv
// Shared types and constants for the multiplexed clock display.
// Latency: none (declarations only).
// Backpressure: not applicable.
package clock_disp_pkg;

  // Digit slot index, 0 = rightmost (seconds units)
  typedef logic [2:0] digit_idx_t;

  localparam digit_idx_t DIG_S0 = 3'd0;
  localparam digit_idx_t DIG_S1 = 3'd1;
  localparam digit_idx_t DIG_M0 = 3'd2;
  localparam digit_idx_t DIG_M1 = 3'd3;
  localparam digit_idx_t DIG_H0 = 3'd4;
  localparam digit_idx_t DIG_H1 = 3'd5;

  // Active-low glyphs, bit order {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_0    = 7'b1000000;
  localparam logic [6:0] SEG_1    = 7'b1111001;
  localparam logic [6:0] SEG_2    = 7'b0100100;
  localparam logic [6:0] SEG_3    = 7'b0110000;
  localparam logic [6:0] SEG_4    = 7'b0011001;
  localparam logic [6:0] SEG_5    = 7'b0010010;
  localparam logic [6:0] SEG_6    = 7'b0000010;
  localparam logic [6:0] SEG_7    = 7'b1111000;
  localparam logic [6:0] SEG_8    = 7'b0000000;
  localparam logic [6:0] SEG_9    = 7'b0010000;
  localparam logic [6:0] SEG_DASH = 7'b0111111;

  // All anodes / all segments dark
  localparam logic [5:0] AN_OFF  = 6'h3F;
  localparam logic [6:0] SEG_OFF = 7'h7F;

endpackage

// File: rtl/bcd_to_seg7.sv
// BCD digit to active-low seven-segment glyph; non-decimal codes show a dash.
// Latency: purely combinational.
// Backpressure: none.
module bcd_to_seg7
  import clock_disp_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg_n
);

  // Glyph lookup; 10..15 fall through to the dash so bad core data is visible
  always_comb begin
    seg_n = SEG_DASH;
    case (bcd)
      4'd0:    seg_n = SEG_0;
      4'd1:    seg_n = SEG_1;
      4'd2:    seg_n = SEG_2;
      4'd3:    seg_n = SEG_3;
      4'd4:    seg_n = SEG_4;
      4'd5:    seg_n = SEG_5;
      4'd6:    seg_n = SEG_6;
      4'd7:    seg_n = SEG_7;
      4'd8:    seg_n = SEG_8;
      4'd9:    seg_n = SEG_9;
      default: seg_n = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/clock_display_mux.sv
// Six-digit multiplexed 7-seg driver for HH:MM:SS with colon, alarm blink, ghost blanking.
// Latency: outputs registered; digit k segments valid one cycle after its slot starts.
// Backpressure: none, free-running scan. Define DISP_LZB_EN to blank a leading zero hour.
module clock_display_mux #(
  parameter int SCAN_DIV     = 1000,
  parameter int BLINK_FRAMES = 50
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] H_out1,
  input  logic [3:0] H_out0,
  input  logic [3:0] M_out1,
  input  logic [3:0] M_out0,
  input  logic [3:0] S_out1,
  input  logic [3:0] S_out0,
  input  logic       Alarm,
  output logic [5:0] an_n,
  output logic [6:0] seg_n,
  output logic       dp_n
);

  import clock_disp_pkg::*;

  localparam int CW = $clog2(SCAN_DIV);
  localparam int FW = $clog2(BLINK_FRAMES + 1);
  localparam logic [CW-1:0] SCAN_LAST = CW'(SCAN_DIV - 1);
  localparam logic [FW-1:0] BLINK_LAST = FW'(BLINK_FRAMES - 1);

  typedef logic [5:0][3:0] digits_t;

  logic [CW-1:0] scan_cnt;
  digit_idx_t    idx;
  digits_t       snap_dig;
  logic          snap_alarm;
  logic          first_snap;
  logic [FW-1:0] frame_cnt;
  logic          blink_vis;

  logic          slot_end;
  logic          frame_wrap;
  logic          take_snap;
  digits_t       live_dig;
  digits_t       cur_dig;
  logic [3:0]    cur_digit;
  logic [6:0]    dec_seg;
  logic          lzb_blank;
  logic [5:0]    an_next;
  logic          dp_next;

  assign slot_end   = (scan_cnt == SCAN_LAST);
  assign frame_wrap = slot_end && (idx == DIG_H1);
  assign take_snap  = first_snap || frame_wrap;
  assign live_dig   = {{2'b00, H_out1}, H_out0, M_out1, M_out0, S_out1, S_out0};

  // On the snapshot edge the registers still hold the previous frame, so the
  // live inputs are forwarded; this lets the very first frame show live data.
  assign cur_dig = take_snap ? live_dig : snap_dig;

  // Pick the digit belonging to the current slot
  always_comb begin
    cur_digit = 4'd0;
    case (idx)
      DIG_S0:  cur_digit = cur_dig[0];
      DIG_S1:  cur_digit = cur_dig[1];
      DIG_M0:  cur_digit = cur_dig[2];
      DIG_M1:  cur_digit = cur_dig[3];
      DIG_H0:  cur_digit = cur_dig[4];
      DIG_H1:  cur_digit = cur_dig[5];
      default: cur_digit = 4'd0;
    endcase
  end

  bcd_to_seg7 u_dec (
    .bcd   (cur_digit),
    .seg_n (dec_seg)
  );

`ifdef DISP_LZB_EN
  assign lzb_blank = (idx == DIG_H1) && (cur_dig[5] == 4'd0);
`else
  assign lzb_blank = 1'b0;
`endif

  // Anode for the next cycle: dark on the slot's last count so the following
  // slot's first cycle is blank while its segments settle.
  always_comb begin
    an_next = AN_OFF;
    if (!slot_end && blink_vis && !lzb_blank)
      an_next = ~(6'd1 << idx);
    dp_next = !(((idx == DIG_M0) || (idx == DIG_H0)) && !cur_dig[0][0]);
  end

  // Slot timer and digit index
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      scan_cnt <= '0;
      idx      <= DIG_S0;
    end else if (slot_end) begin
      scan_cnt <= '0;
      idx      <= (idx == DIG_H1) ? DIG_S0 : idx + 3'd1;
    end else begin
      scan_cnt <= scan_cnt + CW'(1);
    end
  end

  // Frame snapshot of the time digits and alarm flag
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      snap_dig   <= '0;
      snap_alarm <= 1'b0;
      first_snap <= 1'b1;
    end else begin
      first_snap <= 1'b0;
      if (take_snap) begin
        snap_dig   <= live_dig;
        snap_alarm <= Alarm;
      end
    end
  end

  // Blink phase: counts frames completed with the alarm on; an alarm drop
  // at the wrap overrides any coincident toggle and forces visible.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      frame_cnt <= '0;
      blink_vis <= 1'b1;
    end else if (take_snap) begin
      if (!Alarm) begin
        frame_cnt <= '0;
        blink_vis <= 1'b1;
      end else if (snap_alarm) begin
        if (frame_cnt == BLINK_LAST) begin
          frame_cnt <= '0;
          blink_vis <= ~blink_vis;
        end else begin
          frame_cnt <= frame_cnt + FW'(1);
        end
      end
    end
  end

  // Registered display outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      an_n  <= AN_OFF;
      seg_n <= SEG_OFF;
      dp_n  <= 1'b1;
    end else begin
      an_n  <= an_next;
      seg_n <= dec_seg;
      dp_n  <= dp_next;
    end
  end

endmodule
